// File: rtl/filter_pass_sequencer.sv
// filter_pass_sequencer: steps through up to four filter stages. For each stage selected
// in the latched mask it enables the stage, muxes the stage's memory requests onto the
// shared SRAM port, waits for the stage's done handshake, then moves on.
//
// Optional macro FILTER_PASS_SEQUENCER_WATCHDOG_EN adds a per-stage RUN watchdog
// (WATCHDOG_CYCLES unpaused cycles) that aborts to DONE and raises a sticky error.
//
// Ports:
//   clk_div_by_two   in   sole clock, rising edge
//   reset            in   synchronous active-high reset (beats pause and start)
//   pause            in   global freeze; also masks mem_wren
//   start            in   level request; dropping it aborts a running sequence
//   stage_mask[3:0]  in   stages to run, latched when the sequence starts
//   stage_done[3:0]  in   per-stage done levels
//   stage_wren/address/data_write   in   per-stage memory requests (4 x 1/18/32)
//   stage_enable[3:0] out one-hot (or zero) stage enable
//   mem_wren/address/data_write     out  shared SRAM port
//   busy, all_done, current_stage[1:0], error  out  status
module filter_pass_sequencer #(
    parameter int unsigned WATCHDOG_CYCLES = 262144
) (
    input  logic         clk_div_by_two,
    input  logic         reset,
    input  logic         pause,
    input  logic         start,
    input  logic [3:0]   stage_mask,
    input  logic [3:0]   stage_done,
    input  logic [3:0]   stage_wren,
    input  logic [71:0]  stage_address,
    input  logic [127:0] stage_data_write,
    output logic [3:0]   stage_enable,
    output logic         mem_wren,
    output logic [17:0]  mem_address,
    output logic [31:0]  mem_data_write,
    output logic         busy,
    output logic         all_done,
    output logic [1:0]   current_stage,
    output logic         error
);

    typedef enum logic [2:0] {StIdle, StSelect, StRun, StRelease, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  mask_q, mask_d;
    logic [1:0]  sel;
    logic        sel_done;
    logic        wd_expire;

    assign sel      = idx_q[1:0];
    assign sel_done = stage_done[sel];

`ifdef FILTER_PASS_SEQUENCER_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(WATCHDOG_CYCLES + 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q, err_d;

    // wd_q counts completed RUN cycles, so this fires on the WATCHDOG_CYCLES-th one.
    assign wd_expire = (wd_q == WdW'(WATCHDOG_CYCLES - 1));
    assign error     = err_q;
`else
    assign wd_expire = 1'b0;
    assign error     = 1'b0;
`endif

    // Next-state logic; pause holds every register.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
`ifdef FILTER_PASS_SEQUENCER_WATCHDOG_EN
        wd_d    = wd_q;
        err_d   = err_q;
`endif
        if (!pause) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mask_d  = stage_mask;
                        idx_d   = 3'd0;
                        state_d = StSelect;
`ifdef FILTER_PASS_SEQUENCER_WATCHDOG_EN
                        err_d   = 1'b0;
`endif
                    end
                end
                StSelect: begin
                    if (!start) begin
                        state_d = StIdle;
                    end else if (idx_q[2]) begin
                        state_d = StDone;
                    end else if (mask_q[sel]) begin
                        state_d = StRun;
`ifdef FILTER_PASS_SEQUENCER_WATCHDOG_EN
                        wd_d    = '0;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        // Skipping the last stage finishes directly, so an empty mask
                        // costs exactly one cycle per stage.
                        if (sel == 2'd3) begin
                            state_d = StDone;
                        end
                    end
                end
                StRun: begin
                    if (!start) begin
                        state_d = StIdle;
                    end else if (sel_done) begin
                        state_d = StRelease;
                    end else if (wd_expire) begin
                        state_d = StDone;
`ifdef FILTER_PASS_SEQUENCER_WATCHDOG_EN
                        err_d   = 1'b1;
`endif
                    end else begin
`ifdef FILTER_PASS_SEQUENCER_WATCHDOG_EN
                        wd_d = wd_q + 1'b1;
`endif
                    end
                end
                StRelease: begin
                    if (!start) begin
                        state_d = StIdle;
                    end else if (!sel_done) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StSelect;
                    end
                end
                StDone: begin
                    if (!start) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_div_by_two) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            mask_q  <= 4'd0;
`ifdef FILTER_PASS_SEQUENCER_WATCHDOG_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
`ifdef FILTER_PASS_SEQUENCER_WATCHDOG_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    // Outputs decode the registered state; the memory path is a zero-latency mux.
    always_comb begin
        stage_enable   = 4'd0;
        mem_wren       = 1'b0;
        mem_address    = 18'd0;
        mem_data_write = 32'd0;
        if (state_q == StRun) begin
            stage_enable[sel] = 1'b1;
            mem_wren          = stage_wren[sel] & ~pause;
            mem_address       = stage_address[sel*18 +: 18];
            mem_data_write    = stage_data_write[sel*32 +: 32];
        end
        busy          = (state_q == StSelect) || (state_q == StRun) || (state_q == StRelease);
        all_done      = (state_q == StDone);
        current_stage = (state_q == StIdle) ? 2'd0 : sel;
    end

endmodule

// File: tb/tb_filter_pass_sequencer.sv
module tb_filter_pass_sequencer;

    logic         clk = 1'b0;
    logic         reset, pause, start;
    logic [3:0]   stage_mask, stage_done, stage_wren;
    logic [71:0]  stage_address;
    logic [127:0] stage_data_write;
    logic [3:0]   stage_enable;
    logic         mem_wren;
    logic [17:0]  mem_address;
    logic [31:0]  mem_data_write;
    logic         busy, all_done, error;
    logic [1:0]   current_stage;

    filter_pass_sequencer #(.WATCHDOG_CYCLES(16)) dut (
        .clk_div_by_two  (clk),
        .reset           (reset),
        .pause           (pause),
        .start           (start),
        .stage_mask      (stage_mask),
        .stage_done      (stage_done),
        .stage_wren      (stage_wren),
        .stage_address   (stage_address),
        .stage_data_write(stage_data_write),
        .stage_enable    (stage_enable),
        .mem_wren        (mem_wren),
        .mem_address     (mem_address),
        .mem_data_write  (mem_data_write),
        .busy            (busy),
        .all_done        (all_done),
        .current_stage   (current_stage),
        .error           (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         p;
        logic [3:0]   wren;
        logic [71:0]  addr;
        logic [127:0] data;
        logic         ew;
        logic [17:0]  ea;
        logic [31:0]  ed;
    } vec_t;

    typedef struct {
        logic        w;
        logic [17:0] a;
        logic [31:0] d;
    } mem_exp_t;

    typedef struct {
        logic [3:0] en;
        logic [1:0] cs;
    } en_exp_t;

    vec_t     vecs[4];
    mem_exp_t mq[$];
    en_exp_t  eq[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input logic [3:0] want, input string name);
        int n = 0;
        while (stage_enable !== want && n < 50) begin
            step();
            n++;
        end
        check(name, stage_enable, want);
    endtask

    task automatic wait_all_done(input string name);
        int n = 0;
        while (all_done !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check(name, all_done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [3:0] last, e, seen_en;
        int         c0, c2, n;
        en_exp_t    ee;
        mem_exp_t   me;
        logic       seen_done;

        // Vector table: DUT sits in RUN on stage 1 while these are applied.
        vecs[0] = '{p: 1'b0, wren: 4'b0011,
                    addr: {18'h11111, 18'h22222, 18'h008C0, 18'h3FFFF},
                    data: {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000},
                    ew: 1'b1, ea: 18'h008C0, ed: 32'hBBBB0001};
        vecs[1] = '{p: 1'b0, wren: 4'b1101,
                    addr: {18'h00001, 18'h00002, 18'h2ABCD, 18'h00003},
                    data: {32'h1, 32'h2, 32'h12345678, 32'h3},
                    ew: 1'b0, ea: 18'h2ABCD, ed: 32'h12345678};
        vecs[2] = '{p: 1'b1, wren: 4'b0010,
                    addr: {18'h0, 18'h0, 18'h15555, 18'h0},
                    data: {32'h0, 32'h0, 32'hCAFEF00D, 32'h0},
                    ew: 1'b0, ea: 18'h15555, ed: 32'hCAFEF00D};
        vecs[3] = '{p: 1'b0, wren: 4'b0010,
                    addr: {18'h3FFFF, 18'h3FFFF, 18'h00000, 18'h3FFFF},
                    data: {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF},
                    ew: 1'b1, ea: 18'h00000, ed: 32'h00000000};

        reset = 1'b1; pause = 1'b0; start = 1'b0; stage_mask = 4'd0; stage_done = 4'd0;
        stage_wren = 4'd0; stage_address = '0; stage_data_write = '0;
        step();
        step();
        check("reset enable", stage_enable, 4'd0);
        check("reset busy", busy, 1'b0);
        check("reset all_done", all_done, 1'b0);
        check("reset current_stage", current_stage, 2'd0);
        check("reset error", error, 1'b0);
        check("reset mem_wren", mem_wren, 1'b0);
        reset = 1'b0;
        step();

        // Mask 0101: stage 0 done after 10 enabled cycles, stage 2 after 5.
        eq.delete();
        eq.push_back('{en: 4'b0001, cs: 2'd0});
        eq.push_back('{en: 4'b0000, cs: 2'd0});
        eq.push_back('{en: 4'b0100, cs: 2'd2});
        eq.push_back('{en: 4'b0000, cs: 2'd0});
        stage_mask = 4'b0101;
        start = 1'b1;
        last = 4'd0; c0 = 0; c2 = 0;
        for (int c = 0; c < 200 && all_done !== 1'b1; c++) begin
            step();
            e = stage_enable;
            check("onehot", ($countones(e) <= 1), 1'b1);
            if (e !== last) begin
                if (eq.size() == 0) begin
                    check("extra enable change", e, last);
                end else begin
                    ee = eq.pop_front();
                    check("enable seq", e, ee.en);
                    if (e != 4'd0) check("current_stage seq", current_stage, ee.cs);
                end
                last = e;
            end
            if (e[0]) begin
                c0++;
                if (c0 == 10) stage_done[0] = 1'b1;
            end
            if (e[2]) begin
                c2++;
                if (c2 == 5) stage_done[2] = 1'b1;
            end
            if (e == 4'd0) stage_done = 4'd0;
        end
        check("seq all_done", all_done, 1'b1);
        check("seq all changes seen", eq.size(), 0);
        check("seq busy in done", busy, 1'b0);
        start = 1'b0;
        step();
        check("done clears", all_done, 1'b0);

        // Empty mask: four SELECT cycles then DONE, nothing enabled.
        stage_mask = 4'd0;
        start = 1'b1;
        n = 0; seen_en = 4'd0;
        for (int c = 0; c < 20 && all_done !== 1'b1; c++) begin
            step();
            if (busy) n++;
            seen_en |= stage_enable;
        end
        check("mask0 select cycles", n, 4);
        check("mask0 no enable", seen_en, 4'd0);
        check("mask0 all_done", all_done, 1'b1);
        start = 1'b0;
        step();

        // Memory mux table on stage 1.
        stage_mask = 4'b0010;
        start = 1'b1;
        wait_en(4'b0010, "reach stage1");
        check("stage1 current_stage", current_stage, 2'd1);
        for (int i = 0; i < 4; i++) begin
            pause = vecs[i].p;
            stage_wren = vecs[i].wren;
            stage_address = vecs[i].addr;
            stage_data_write = vecs[i].data;
            mq.push_back('{w: vecs[i].ew, a: vecs[i].ea, d: vecs[i].ed});
            @(negedge clk);
            me = mq.pop_front();
            check("vec mem_wren", mem_wren, me.w);
            check("vec mem_address", mem_address, me.a);
            check("vec mem_data", mem_data_write, me.d);
            check("vec enable", stage_enable, 4'b0010);
        end
        pause = 1'b0;

        // Pause 3 cycles with done already asserted: nothing may move.
        @(posedge clk);
        #1;
        pause = 1'b1;
        stage_wren = 4'b0010;
        stage_done = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            check("pause mem_wren", mem_wren, 1'b0);
            check("pause enable", stage_enable, 4'b0010);
            check("pause stage", current_stage, 2'd1);
        end
        pause = 1'b0;
        step();
        check("release enable", stage_enable, 4'd0);
        check("release busy", busy, 1'b1);
        check("release mem_wren", mem_wren, 1'b0);
        check("release mem_address", mem_address, 18'd0);
        stage_done = 4'd0;
        wait_all_done("stage1 seq done");
        start = 1'b0;
        step();

        // Abort mid-RUN on stage 2.
        stage_mask = 4'b0100;
        start = 1'b1;
        seen_done = 1'b0;
        wait_en(4'b0100, "reach stage2");
        step();
        step();
        seen_done |= all_done;
        check("stage2 current_stage", current_stage, 2'd2);
        start = 1'b0;
        step();
        seen_done |= all_done;
        check("abort enable", stage_enable, 4'd0);
        check("abort busy", busy, 1'b0);
        check("abort all_done never", seen_done, 1'b0);
        check("abort current_stage", current_stage, 2'd0);

        // Reset mid-RUN, with pause and start both high.
        stage_mask = 4'b0010;
        start = 1'b1;
        wait_en(4'b0010, "reach stage1 again");
        stage_wren = 4'b1111;
        stage_address = {18'h00004, 18'h00003, 18'h00002, 18'h00001};
        stage_data_write = {32'hD, 32'hC, 32'hB, 32'hA};
        reset = 1'b1;
        pause = 1'b1;
        step();
        check("rst enable", stage_enable, 4'd0);
        check("rst mem_wren", mem_wren, 1'b0);
        check("rst mem_address", mem_address, 18'd0);
        check("rst mem_data", mem_data_write, 32'd0);
        check("rst busy", busy, 1'b0);
        check("rst all_done", all_done, 1'b0);
        check("rst current_stage", current_stage, 2'd0);
        reset = 1'b0;
        pause = 1'b0;
        stage_mask = 4'b1111;
        step();
        step();
        check("restart enable", stage_enable, 4'b0001);
        check("restart stage", current_stage, 2'd0);
        check("restart mem_wren", mem_wren, 1'b1);
        check("restart mem_address", mem_address, 18'h00001);
        start = 1'b0;
        stage_wren = 4'd0;
        step();

        // Stage 3 never finishes.
        stage_mask = 4'b1000;
        start = 1'b1;
        wait_en(4'b1000, "reach stage3");
`ifdef FILTER_PASS_SEQUENCER_WATCHDOG_EN
        n = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (stage_enable == 4'b1000) n++;
            else break;
        end
        check("wd enabled cycles", n + 1, 16);
        check("wd enable dropped", stage_enable, 4'd0);
        check("wd error", error, 1'b1);
        check("wd all_done", all_done, 1'b1);
        start = 1'b0;
        step();
        check("wd error sticky", error, 1'b1);
        start = 1'b1;
        step();
        check("wd error cleared", error, 1'b0);
`else
        for (int c = 0; c < 40; c++) step();
        check("no wd enable held", stage_enable, 4'b1000);
        check("no wd error", error, 1'b0);
        check("no wd all_done", all_done, 1'b0);
`endif
        start = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
